mvu_input_loader: RTL and testbench

MVU_INPUT_LOADER -- requirements
Module: mvu_input_loader

---
 rtl/mvu_pkg.sv | 17 +
 rtl/mvu_input_loader_chan.sv | 113 +++++++++++
 rtl/mvu_input_loader.sv | 109 ++++++++++
 tb/tb_mvu_input_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared MVU constants and loader channel state type
package mvu_pkg;

  localparam int NMVU          = 8;
  localparam int N             = 64;
  localparam int XPR_LEN       = 32;
  localparam int BDBANKA       = 15;
  localparam int BDBANKW       = N;
  localparam int MAX_DATA_PREC = 16;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_FILL  = 2'd1,
    CH_DRAIN = 2'd2
  } chan_state_t;

endpackage

// File: rtl/mvu_input_loader_chan.sv
// rtl/mvu_input_loader_chan.sv - one loader channel: element intake, bit-plane transpose, plane drain
module mvu_input_loader_chan
  import mvu_pkg::*;
#(
  parameter int NUM_WORDS     = mvu_pkg::N,
  parameter int XLEN          = mvu_pkg::XPR_LEN,
  parameter int MVU_ADDR_LEN  = mvu_pkg::BDBANKA,
  parameter int MAX_DATA_PREC = mvu_pkg::MAX_DATA_PREC,
  parameter int PW            = $clog2(MAX_DATA_PREC + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PW-1:0]           prec,
  input  logic [MVU_ADDR_LEN-1:0] baddr,
  input  logic                    start,
  input  logic [XLEN-1:0]         iword,
  input  logic                    ivalid,
  output logic                    iready,
  input  logic                    wr_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    draining,
  output logic [MVU_ADDR_LEN-1:0] wr_addr,
  output logic [NUM_WORDS-1:0]    wr_word
);

  localparam int CW = $clog2(NUM_WORDS);

  chan_state_t                 state;
  chan_state_t                 state_nxt;
  logic [PW-1:0]               prec_r;
  logic [PW-1:0]               wcnt;
  logic [PW-1:0]               plane_sel;
  logic [MVU_ADDR_LEN-1:0]     baddr_r;
  logic [CW-1:0]               ecnt;
  logic [NUM_WORDS-1:0]        plane [MAX_DATA_PREC];
  logic                        start_ok;
  logic                        accept;
  logic                        last_write;

  // Element bits above the maximum precision never reach a plane.
  if (XLEN > MAX_DATA_PREC) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^iword[XLEN-1:MAX_DATA_PREC];
  end

  assign start_ok   = (prec != '0) && (prec <= PW'(MAX_DATA_PREC));
  assign iready     = (state == CH_FILL);
  assign draining   = (state == CH_DRAIN);
  assign busy       = (state != CH_IDLE);
  assign accept     = ivalid && iready;
  assign last_write = wr_ack && (wcnt == prec_r - PW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CH_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> FILL on a legal start, FILL -> DRAIN on the last element, DRAIN -> IDLE on the last write.
  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE:  if (start && start_ok) state_nxt = CH_FILL;
      CH_FILL:  if (ivalid && (ecnt == CW'(NUM_WORDS - 1))) state_nxt = CH_DRAIN;
      CH_DRAIN: if (last_write) state_nxt = CH_IDLE;
      default:  state_nxt = CH_IDLE;
    endcase
  end

  // Block parameters, counters, plane shift registers and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prec_r  <= '0;
      baddr_r <= '0;
      ecnt    <= '0;
      wcnt    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int j = 0; j < MAX_DATA_PREC; j++) plane[j] <= '0;
    end else begin
      done <= (state == CH_DRAIN) && last_write;
      err  <= (state == CH_IDLE) && start && !start_ok;
      if ((state == CH_IDLE) && start && start_ok) begin
        prec_r  <= prec;
        baddr_r <= baddr;
        ecnt    <= '0;
        wcnt    <= '0;
      end
      if (accept) begin
        ecnt <= ecnt + CW'(1);
        for (int j = 0; j < MAX_DATA_PREC; j++) begin
          if (PW'(j) < prec_r) plane[j] <= {plane[j][NUM_WORDS-2:0], iword[j]};
        end
      end
      if ((state == CH_DRAIN) && wr_ack) wcnt <= wcnt + PW'(1);
    end
  end

  // Planes leave most-significant first; the address steps with the write count and wraps naturally.
  assign wr_addr   = baddr_r + MVU_ADDR_LEN'(wcnt);
  assign plane_sel = prec_r - PW'(1) - wcnt;

  // Plane select mux.
  always_comb begin
    wr_word = '0;
    for (int j = 0; j < MAX_DATA_PREC; j++) begin
      if (PW'(j) == plane_sel) wr_word = plane[j];
    end
  end

endmodule

// File: rtl/mvu_input_loader.sv
// rtl/mvu_input_loader.sv - multi-channel MVU input loader with round-robin write arbitration
module mvu_input_loader
  import mvu_pkg::*;
#(
  parameter int NCH           = mvu_pkg::NMVU,
  parameter int NUM_WORDS     = mvu_pkg::N,
  parameter int XLEN          = mvu_pkg::XPR_LEN,
  parameter int MVU_ADDR_LEN  = mvu_pkg::BDBANKA,
  parameter int MVU_DATA_LEN  = mvu_pkg::BDBANKW,
  parameter int MAX_DATA_PREC = mvu_pkg::MAX_DATA_PREC
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NCH*$clog2(MAX_DATA_PREC+1)-1:0]    prec,
  input  logic [NCH*MVU_ADDR_LEN-1:0]               baddr,
  input  logic [NCH-1:0]                            start,
  input  logic [NCH*XLEN-1:0]                       iword,
  input  logic [NCH-1:0]                            ivalid,
  output logic [NCH-1:0]                            iready,
  output logic [NCH-1:0]                            busy,
  output logic [NCH-1:0]                            done,
  output logic [NCH-1:0]                            err,
  output logic [NCH-1:0]                            wrc_en,
  input  logic [NCH-1:0]                            wrc_grnt,
  output logic [MVU_ADDR_LEN-1:0]                   wrc_addr,
  output logic [MVU_DATA_LEN-1:0]                   wrc_word
);

  localparam int PW = $clog2(MAX_DATA_PREC + 1);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]          drain_v;
  logic [NCH-1:0]          wr_ack;
  logic [2*NCH-1:0]        rot;
  logic [MVU_ADDR_LEN-1:0] ch_addr [NCH];
  logic [MVU_DATA_LEN-1:0] ch_word [NCH];
  logic [SW-1:0]           ptr;
  logic [SW-1:0]           hold_c;
  logic [SW-1:0]           sel;
  logic                    hold_v;
  logic                    sel_v;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    mvu_input_loader_chan #(
      .NUM_WORDS     (NUM_WORDS),
      .XLEN          (XLEN),
      .MVU_ADDR_LEN  (MVU_ADDR_LEN),
      .MAX_DATA_PREC (MAX_DATA_PREC),
      .PW            (PW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .prec     (prec[c*PW +: PW]),
      .baddr    (baddr[c*MVU_ADDR_LEN +: MVU_ADDR_LEN]),
      .start    (start[c]),
      .iword    (iword[c*XLEN +: XLEN]),
      .ivalid   (ivalid[c]),
      .iready   (iready[c]),
      .wr_ack   (wr_ack[c]),
      .busy     (busy[c]),
      .done     (done[c]),
      .err      (err[c]),
      .draining (drain_v[c]),
      .wr_addr  (ch_addr[c]),
      .wr_word  (ch_word[c])
    );
  end

  assign rot = {drain_v, drain_v} >> ptr;

  // Arbiter pick: a stalled winner is held, otherwise the first draining channel at or after the pointer.
  always_comb begin
    sel   = hold_c;
    sel_v = hold_v;
    if (!hold_v) begin
      sel   = '0;
      sel_v = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
        if (rot[i]) begin
          sel   = SW'((int'(ptr) + i) % NCH);
          sel_v = 1'b1;
        end
      end
    end
  end

  assign wrc_en   = sel_v ? (NCH'(1) << sel) : '0;
  assign wr_ack   = wrc_en & wrc_grnt;
  assign wrc_addr = sel_v ? ch_addr[sel] : '0;
  assign wrc_word = sel_v ? ch_word[sel] : '0;

  // Priority pointer and winner hold: rotate past the winner on a granted write, hold it while ungranted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      hold_v <= 1'b0;
      hold_c <= '0;
    end else if (sel_v) begin
      if (wrc_grnt[sel]) begin
        hold_v <= 1'b0;
        ptr    <= (sel == SW'(NCH - 1)) ? '0 : sel + SW'(1);
      end else begin
        hold_v <= 1'b1;
        hold_c <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mvu_input_loader.sv
// tb/tb_mvu_input_loader.sv - directed self-checking bench for mvu_input_loader
module tb_mvu_input_loader;

  localparam int NCH = 8;
  localparam int PW  = 5;
  localparam int AW  = 15;
  localparam int DW  = 64;
  localparam int XL  = 32;

  localparam logic [63:0] W5  = 64'h5555555555555555;
  localparam logic [63:0] W3  = 64'h3333333333333333;
  localparam logic [63:0] WF  = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] WFF = 64'h00FF00FF00FF00FF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*PW-1:0] prec;
  logic [NCH*AW-1:0] baddr;
  logic [NCH-1:0]    start;
  logic [NCH*XL-1:0] iword;
  logic [NCH-1:0]    ivalid;
  logic [NCH-1:0]    iready;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    err;
  logic [NCH-1:0]    wrc_en;
  logic [NCH-1:0]    wrc_grnt;
  logic [AW-1:0]     wrc_addr;
  logic [DW-1:0]     wrc_word;

  int          src_idx  [NCH];
  int          src_mode [NCH];
  logic [NCH-1:0] src_en;
  int          log_ch [$];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_word [$];
  int          done_seen = 0;
  int          errors = 0;
  int          checks = 0;

  mvu_input_loader #(
    .NCH(NCH), .NUM_WORDS(64), .XLEN(XL), .MVU_ADDR_LEN(AW), .MVU_DATA_LEN(DW), .MAX_DATA_PREC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .start(start),
    .iword(iword), .ivalid(ivalid), .iready(iready), .busy(busy), .done(done),
    .err(err), .wrc_en(wrc_en), .wrc_grnt(wrc_grnt), .wrc_addr(wrc_addr), .wrc_word(wrc_word)
  );

  always #5 clk = ~clk;

  // Element sources: mode 0 sends i&3, mode 1 sends i.
  always_comb begin
    iword  = '0;
    ivalid = '0;
    for (int c = 0; c < NCH; c++) begin
      ivalid[c] = src_en[c] && (src_idx[c] < 64);
      iword[c*XL +: XL] = (src_mode[c] == 0) ? (src_idx[c] & 3) : src_idx[c];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n || (start[c] && !busy[c])) src_idx[c] <= 0;
      else if (ivalid[c] && iready[c])      src_idx[c] <= src_idx[c] + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (wrc_en[c] && wrc_grnt[c]) begin
          log_ch.push_back(c);
          log_addr.push_back(wrc_addr);
          log_word.push_back(wrc_word);
        end
      end
      if (|done) done_seen++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int p, input int b, input int mode);
    prec[c*PW +: PW]  = PW'(p);
    baddr[c*AW +: AW] = AW'(b);
    src_mode[c]       = mode;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = '0;
    src_en   = '0;
    wrc_grnt = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int ch, output int n);
    n = 0;
    while (!done[ch] && n < 300) begin
      tick();
      n++;
    end
    check($sformatf("done%0d_seen", ch), 64'(done[ch]), 64'd1);
  endtask

  task automatic check_write(input string tag, input int k, input int ch, input logic [AW-1:0] a, input logic [63:0] w);
    if (k < log_ch.size()) begin
      check({tag, "_ch"}, 64'(log_ch[k]), 64'(ch));
      check({tag, "_addr"}, 64'(log_addr[k]), 64'(a));
      check({tag, "_word"}, log_word[k], w);
    end else begin
      check({tag, "_missing"}, 64'(log_ch.size()), 64'(k + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_iready"}, 64'(iready), 64'd0);
    check({tag, "_busy"},   64'(busy),   64'd0);
    check({tag, "_done"},   64'(done),   64'd0);
    check({tag, "_err"},    64'(err),    64'd0);
    check({tag, "_wrc_en"}, 64'(wrc_en), 64'd0);
    check({tag, "_addr"},   64'(wrc_addr), 64'd0);
    check({tag, "_word"},   wrc_word,    64'd0);
  endtask

  initial begin
    int n;
    int base;
    int ds;
    prec  = '0;
    baddr = '0;
    for (int c = 0; c < NCH; c++) src_mode[c] = 0;

    // Reset state.
    do_reset();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Basic block: prec 2, element i&3, latency and plane order.
    do_reset();
    set_ch(0, 2, 'h10, 0);
    src_en[0] = 1'b1;
    base = log_ch.size();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("basic_busy", 64'(busy[0]), 64'd1);
    check("basic_iready", 64'(iready[0]), 64'd1);
    wait_done(0, n);
    check("basic_latency", 64'(n + 1), 64'd67);
    check("basic_busy_at_done", 64'(busy[0]), 64'd0);
    check("basic_nwr", 64'(log_ch.size() - base), 64'd2);
    check_write("basic_w0", base, 0, 'h10, W3);
    check_write("basic_w1", base + 1, 0, 'h11, W5);
    tick();
    check("basic_done_pulse", 64'(done[0]), 64'd0);

    // Illegal precision on start.
    base = log_ch.size();
    set_ch(0, 0, 'h10, 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("err0_pulse", 64'(err), 64'h01);
    check("err0_busy", 64'(busy), 64'd0);
    tick();
    check("err0_clear", 64'(err), 64'd0);
    set_ch(2, 17, 'h10, 0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    check("err17_pulse", 64'(err), 64'h04);
    check("err17_busy", 64'(busy), 64'd0);
    tick();
    check("err17_clear", 64'(err), 64'd0);
    check("err_no_writes", 64'(log_ch.size() - base), 64'd0);

    // Two channels draining together; a mid-fill start is ignored.
    do_reset();
    set_ch(0, 4, 'h20, 1);
    set_ch(3, 4, 'h40, 0);
    src_en[0] = 1'b1;
    src_en[3] = 1'b1;
    base = log_ch.size();
    start[0] = 1'b1;
    start[3] = 1'b1;
    tick();
    start = '0;
    repeat (5) tick();
    prec[0*PW +: PW] = '0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("ignore_err", 64'(err[0]), 64'd0);
    check("ignore_busy", 64'(busy[0]), 64'd1);
    wait_done(3, n);
    check("rr_nwr", 64'(log_ch.size() - base), 64'd8);
    check_write("rr0_0", base + 0, 0, 'h20, WFF);
    check_write("rr3_0", base + 1, 3, 'h40, 64'd0);
    check_write("rr0_1", base + 2, 0, 'h21, WF);
    check_write("rr3_1", base + 3, 3, 'h41, 64'd0);
    check_write("rr0_2", base + 4, 0, 'h22, W3);
    check_write("rr3_2", base + 5, 3, 'h42, W3);
    check_write("rr0_3", base + 6, 0, 'h23, W5);
    check_write("rr3_3", base + 7, 3, 'h43, W5);

    // Grant withheld: request and data must hold still.
    do_reset();
    wrc_grnt = '0;
    set_ch(1, 2, 'h100, 0);
    src_en[1] = 1'b1;
    base = log_ch.size();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (!wrc_en[1] && n < 100) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_en", k), 64'(wrc_en), 64'h02);
      check($sformatf("stall%0d_addr", k), 64'(wrc_addr), 64'h100);
      check($sformatf("stall%0d_word", k), wrc_word, W3);
      tick();
    end
    check("stall_no_write", 64'(log_ch.size() - base), 64'd0);
    wrc_grnt = '1;
    wait_done(1, n);
    check("stall_nwr", 64'(log_ch.size() - base), 64'd2);
    check_write("stall_w0", base, 1, 'h100, W3);
    check_write("stall_w1", base + 1, 1, 'h101, W5);

    // Address wrap at the top of the address space.
    do_reset();
    set_ch(2, 3, 'h7FFF, 1);
    src_en[2] = 1'b1;
    base = log_ch.size();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    wait_done(2, n);
    check("wrap_nwr", 64'(log_ch.size() - base), 64'd3);
    check_write("wrap_w0", base, 2, 'h7FFF, WF);
    check_write("wrap_w1", base + 1, 2, 'h0000, W3);
    check_write("wrap_w2", base + 2, 2, 'h0001, W5);

    // Reset in the middle of filling, then a clean block.
    do_reset();
    set_ch(0, 2, 'h10, 0);
    src_en[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (src_idx[0] != 30 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_reached30", 64'(src_idx[0]), 64'd30);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    base = log_ch.size();
    ds   = done_seen;
    repeat (80) tick();
    check("midrst_no_writes", 64'(log_ch.size() - base), 64'd0);
    check("midrst_no_done", 64'(done_seen - ds), 64'd0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, n);
    check("after_latency", 64'(n + 1), 64'd67);
    check("after_nwr", 64'(log_ch.size() - base), 64'd2);
    check_write("after_w0", base, 0, 'h10, W3);
    check_write("after_w1", base + 1, 0, 'h11, W5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
